// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: address decode, data-phase response
// mux, built-in default slave with two-cycle ERROR, optional wait-state
// timeout, and a saturating error counter with sticky timeout flag.
module ahb_lite_interconnect #(
  parameter int                 W        = 32,
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h6000_0000, 32'h4000_0000,
                                            32'h2000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {4{32'hE000_0000}},
  parameter int                 TIMEOUT  = 0
) (
  input  logic              fclk,
  input  logic              resetn,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  output logic              hready,
  output logic              hresp,
  output logic [W-1:0]      hrdata,
  output logic [NSLV-1:0]   s_hsel,
  input  logic [NSLV-1:0]   s_hreadyout,
  input  logic [NSLV-1:0]   s_hresp,
  input  logic [NSLV*W-1:0] s_hrdata,
  output logic [7:0]        err_count,
  output logic              timeout_flag,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT > 0);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t          state;
  state_t          state_nxt;
  logic            addr_found;
  logic            addr_unmapped;
  logic [NSLV-1:0] dp_sel;
  logic            dp_def;
  logic            dp_active;
  logic            slv_ready;
  logic            slv_resp;
  logic [W-1:0]    slv_rdata;
  logic [15:0]     wait_cnt;
  logic            wait_active;
  logic            wait_expire;
  logic            timeout_hit;
  logic            err_inc;
  logic            unused_htrans0;

  // Only the NONSEQ/SEQ distinction matters here; bit 0 is not needed.
  assign unused_htrans0 = htrans[0];

  // Address decode: first matching slot wins, nothing selected when unmapped.
  always_comb begin
    s_hsel     = '0;
    addr_found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!addr_found &&
          ((haddr & SLV_MASK[32*i +: 32]) ==
           (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
        s_hsel[i]  = 1'b1;
        addr_found = 1'b1;
      end
    end
  end

  assign addr_unmapped = ~addr_found;

  // Capture which target owns the upcoming data phase whenever the bus advances.
  always_ff @(posedge fclk or negedge resetn) begin
    if (!resetn) begin
      dp_sel    <= '0;
      dp_def    <= 1'b1;
      dp_active <= 1'b0;
    end else if (hready) begin
      dp_sel    <= s_hsel;
      dp_def    <= addr_unmapped;
      dp_active <= htrans[1];
    end
  end

  // Select the response of the slave that owns the data phase.
  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dp_sel[i]) begin
        slv_ready = s_hreadyout[i];
        slv_resp  = s_hresp[i];
        slv_rdata = s_hrdata[W*i +: W];
      end
    end
  end

  assign wait_active = (state == OKAY) && !dp_def && dp_active && !slv_ready;
  assign wait_expire = TO_EN && wait_active && (wait_cnt == TO_LAST);

  // Response state register.
  always_ff @(posedge fclk or negedge resetn) begin
    if (!resetn) begin
      state <= OKAY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and master-facing response; error states mask the slave.
  always_comb begin
    state_nxt   = state;
    hready      = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    timeout_hit = 1'b0;
    case (state)
      OKAY: begin
        if (!dp_def) begin
          hready = slv_ready;
          hresp  = slv_resp;
          hrdata = slv_rdata;
        end
        if (wait_expire) begin
          state_nxt   = ERR1;
          timeout_hit = 1'b1;
        end else if (hready && htrans[1] && addr_unmapped) begin
          state_nxt = ERR1;
        end
      end
      ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
        if (htrans[1] && addr_unmapped) begin
          state_nxt = ERR1;
        end else begin
          state_nxt = OKAY;
        end
      end
      default: begin
        state_nxt = OKAY;
      end
    endcase
  end

  // Count consecutive stalled slave cycles; any progress or error restarts it.
  always_ff @(posedge fclk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (!TO_EN || !wait_active || wait_expire) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign err_inc = (state_nxt == ERR1) && (state != ERR1);

  // Error statistics; a clear in the same cycle as a new error discards it.
  always_ff @(posedge fclk or negedge resetn) begin
    if (!resetn) begin
      err_count    <= '0;
      timeout_flag <= 1'b0;
    end else if (err_clr) begin
      err_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ahb_lite_interconnect.md
AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 Parameter W, default 32: data bus width, 32 or 64.
REQ-002 Parameter NSLV, default 4: number of slave ports, 1..8.
REQ-003 Parameter SLV_BASE, default {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}: packed NSLV x 32 bit base addresses, slot i = bits [32i+31:32i].
REQ-004 Parameter SLV_MASK, default {4{32'hE000_0000}}: packed NSLV x 32 bit compare masks.
REQ-005 Parameter TIMEOUT, default 0: wait-state limit in cycles; 0 disables the timeout function.
REQ-006 fclk, input, 1: clock for all sequential logic.
REQ-007 resetn, input, 1: asynchronous active-low reset.
REQ-008 haddr, input, 32: master address.
REQ-009 htrans, input, 2: master transfer type.
REQ-010 hready, output, 1: ready to the master and to all slaves.
REQ-011 hresp, output, 1: response to the master (0 = OKAY, 1 = ERROR).
REQ-012 hrdata, output, W: read data to the master.
REQ-013 s_hsel, output, NSLV: slave selects.
REQ-014 s_hreadyout, input, NSLV: per-slave ready.
REQ-015 s_hresp, input, NSLV: per-slave response.
REQ-016 s_hrdata, input, NSLV*W: packed slave read data.
REQ-017 err_count, output, 8: saturating error counter.
REQ-018 timeout_flag, output, 1: sticky timeout indicator.
REQ-019 err_clr, input, 1: synchronous clear of err_count and timeout_flag.

Function
REQ-020 s_hsel[i] SHALL be combinational and SHALL equal ((haddr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i])), qualified so that only the lowest matching index is asserted.
REQ-021 When no slot matches, the default slave SHALL be selected and all s_hsel SHALL be 0.
REQ-022 A data-phase select register (one-hot NSLV plus default, plus an active bit = htrans[1]) SHALL load only on cycles where hready=1.
REQ-023 For a slave i in the data phase, hready, hresp and hrdata SHALL pass s_hreadyout[i], s_hresp[i] and s_hrdata slice i combinationally.
REQ-024 The default slave with IDLE/BUSY in the data phase SHALL respond hready=1, hresp=0, hrdata=0.
REQ-025 Response FSM states: OKAY, ERR1, ERR2.
REQ-026 OKAY->ERR1 SHALL occur when a NONSEQ/SEQ transfer to the default slave is accepted (hready=1).
REQ-027 In ERR1 the block SHALL drive hready=0, hresp=1; ERR1->ERR2 unconditionally.
REQ-028 In ERR2 the block SHALL drive hready=1, hresp=1; ERR2->OKAY unless a new unmapped NONSEQ/SEQ is accepted in ERR2, in which case ERR2->ERR1.
REQ-029 When TIMEOUT>0, a 16-bit wait counter SHALL increment each cycle a slave data phase has hready=0, and SHALL clear on hready=1.
REQ-030 When the wait counter reaches TIMEOUT, the FSM SHALL enter ERR1, the slave's outputs SHALL be masked until ERR2 completes, and timeout_flag SHALL set.
REQ-031 err_count SHALL increment by 1 on each entry to ERR1 and SHALL saturate at 8'hFF.
REQ-032 err_clr SHALL zero err_count and timeout_flag; a simultaneous increment SHALL be lost and clear wins.
REQ-033 A slave two-cycle ERROR passes through unchanged and SHALL NOT increment err_count.

Reset
REQ-034 While resetn=0, the outputs SHALL be: hready=1, hresp=0, hrdata=0, err_count=0, timeout_flag=0; FSM=OKAY; data-phase register = default, inactive; wait counter=0.
REQ-035 s_hsel SHALL remain combinational from haddr during reset.
REQ-036 Reset asserted mid-ERR1 or mid-wait SHALL abort to the reset state immediately; no ERROR cycle SHALL complete after reset release.

Verification
REQ-037 Decode: defaults, haddr=32'h2000_0010 NONSEQ -> s_hsel=4'b0010; data phase hrdata = slave1 data, hresp=0.
REQ-038 Unmapped: SLV_MASK slot3 = 0 with NSLV=3, haddr=32'h8000_0000 NONSEQ -> next cycle hready=0/hresp=1, then hready=1/hresp=1, err_count=1.
REQ-039 Back-to-back unmapped NONSEQ accepted in ERR2 -> ERR1 re-entered with no OKAY cycle; err_count=2.
REQ-040 Timeout: TIMEOUT=8, slave0 holds hreadyout=0 -> ERR1 after 8 wait cycles, timeout_flag=1, err_count=1; slave hreadyout ignored until OKAY.
REQ-041 Saturation/clear: 260 unmapped transfers -> err_count=8'hFF; err_clr coinciding with ERR1 entry -> err_count=0.
REQ-042 Reset asserted during ERR1 -> hready=1, hresp=0 in the same cycle; first transfer after release gets a normal OKAY.
